proc_dmem_arb: RTL
==================

Name: proc_dmem_arb

Overview:
Two-requester arbiter that shares the single data-memory port of the processor memory between two requesters:
- the processor data path (requester P);
- the external host/loader/debug interface (requester X).
- Round-robin grant, fixed-latency pipelined memory port, per-request response routing back to the issuing requester.
- Sits between ctrl/dpath, the external dmem interface, and the memory's dmemreq_*/dmemresp_* port.

Parameters:
- LAT, 1, memory read latency in cycles from the request cycle to mem_resp_rdata valid (legal 1..4).
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- p_req_val  input  1  P request valid
- p_req_rdy  output  1  P request accepted this cycle
- p_req_type  input  1  0=read, 1=write
- p_req_addr  input  32  byte address
- p_req_wdata  input  32  write data
- p_resp_val  output  1  P response valid
- p_resp_rdata  output  32  P read data (0 for write ack)
- x_req_val, x_req_rdy, x_req_type, x_req_addr, x_req_wdata, x_resp_val, x_resp_rdata: same as the P ports, for requester X.
- mem_req_val  output  1  memory request valid
- mem_req_type  output  1  0=read, 1=write
- mem_req_addr  output  32  memory address
- mem_req_wdata  output  32  memory write data
- mem_resp_rdata  input  32  read data, valid LAT cycles after mem_req_val
- perf_conflict_cnt  output  CNT_W  cycles where both requesters were valid
- perf_p_grant_cnt  output  CNT_W  requests granted to P
- perf_x_grant_cnt  output  CNT_W  requests granted to X

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - last_grant = X, so P wins the first conflict.
  - Tag pipeline cleared.
  - All resp_val = 0 and all counters = 0.
  - Combinational outputs follow from the cleared state.
- Grant is combinational:
  - Only one valid requester: it wins.
  - Both valid: the requester that is not last_grant wins.
  - Winner's rdy = 1; loser's rdy = 0. rdy = 0 when the requester's val = 0.
- A request is accepted ("fires") when val & rdy.
  - mem_req_val = OR of fires.
  - mem_req_type/addr/wdata are muxed from the winner; all zero when idle.
- last_grant updates to the winner on any fire; it holds when idle.
- One request is accepted per cycle, fully pipelined, with no back-pressure from memory.
- Tag pipeline: LAT stages of {valid, owner, is_read}. Stage 0 is loaded on fire; the stages shift every cycle.
- At the final stage with valid = 1:
  - resp_val of that owner = 1 for exactly one cycle.
  - rdata = mem_resp_rdata if is_read, else 0.
  - The non-owner sees resp_val = 0 and rdata = 0.
- Responses return in issue order. Each requester sees its own responses in its own issue order.
- Writes are acknowledged LAT cycles after issue.
- A requester holding val while losing keeps its request stable; it is served on the next cycle because of round-robin, so starvation is at most 1 cycle.
- Asserting rst mid-operation drops all in-flight responses: no resp_val after reset deassertion for requests issued before reset.

Optional Feature:
- Macro: PROC_DMEM_ARB_PERF_EN.
- With the macro defined:
  - perf_conflict_cnt increments each cycle p_req_val & x_req_val.
  - perf_p_grant_cnt / perf_x_grant_cnt increment on each P/X fire.
  - All counters saturate at 2^CNT_W-1 and clear only on reset.
- Without the macro: the counter registers are not built and all three perf outputs are tied to 0.
- Arbitration and responses are identical in both builds.

Decomposition:
- Package proc_dmem_arb_pkg:
  - constants OWNER_P=1'b0, OWNER_X=1'b1, MEM_READ=1'b0, MEM_WRITE=1'b1;
  - typedef struct arb_tag_t {logic val; logic owner; logic is_read;}.
- One sub-module, proc_dmem_arb_rr: 2-way round-robin picker.
  - Inputs: clk, rst, req[1:0], fire.
  - Outputs: gnt[1:0].
  - Holds the last_grant register.
- Tag pipeline and response demux live in the top module.

Test Plan:
- Reset then idle: after rst, all rdy/resp_val = 0, mem_req_val = 0, perf counters = 0 for 5 cycles.
- Single P read, LAT=1: P reads addr 0x100, mem returns 0xDEADBEEF the next cycle -> p_resp_val = 1 one cycle later with rdata 0xDEADBEEF; x_resp_val stays 0.
- Conflict from reset: both valid in cycle 0 (P read 0x10, X write 0x20 data 0x55) -> P granted cycle 0, X granted cycle 1; responses arrive to P then X, X rdata = 0.
- Sustained contention, 6 cycles, LAT=3: grants alternate P,X,P,X,P,X; with the feature, perf_conflict_cnt = 6 (loser holding val) and each grant count = 3.
- Back-to-back X writes then an X read of the same addr 0x40 (write 0x1234) -> read response rdata 0x1234; ordering preserved.
- Reset mid-flight: issue P read at LAT=3, assert rst the next cycle -> no p_resp_val after release; next conflict is granted to P.

Source files
------------

// File: rtl/proc_dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_dmem_arb_pkg
// Description : Shared constants and types for the data-memory arbiter.
//               Owner encoding: P (processor data path) = 0,
//               X (host/loader/debug) = 1. Request types follow the
//               memory port encoding (0 = read, 1 = write).
// Revision    : 1.0 - initial release
// ============================================================================
package proc_dmem_arb_pkg;

    localparam logic OWNER_P   = 1'b0;
    localparam logic OWNER_X   = 1'b1;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // One entry of the in-flight tag pipeline.
    typedef struct packed {
        logic val;
        logic owner;
        logic is_read;
    } arb_tag_t;

endpackage
`default_nettype wire

// File: rtl/proc_dmem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : proc_dmem_arb_rr
// Description : Two-way round-robin picker. Holds the last-grant register
//               and produces a one-hot (or zero) grant.
//               req[0] = requester P, req[1] = requester X.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               req  - request vector {X, P}
//               fire - a granted request was accepted this cycle
//               gnt  - grant vector {X, P}, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module proc_dmem_arb_rr
    import proc_dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       fire,
    output logic [1:0] gnt
);

    logic r_last_grant;

    // P wins unless X also requests and P was the previous winner.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || (r_last_grant == OWNER_X))) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // Reset to X so that P takes the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= OWNER_X;
        end else if (fire) begin
            r_last_grant <= gnt[1] ? OWNER_X : OWNER_P;
        end
    end

endmodule
`default_nettype wire

// File: rtl/proc_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module      : proc_dmem_arb
// Description : Shares one fixed-latency pipelined data-memory port between
//               the processor data path (P) and the external host interface
//               (X). Round-robin grant, one request per cycle, responses
//               routed back to the issuing requester LAT cycles after issue.
//               Optional performance counters are built when the macro
//               PROC_DMEM_ARB_PERF_EN is defined; otherwise tied to zero.
// Ports       : clk, rst            - clock, async active-high reset
//               p_req_* / p_resp_*  - requester P request/response
//               x_req_* / x_resp_*  - requester X request/response
//               mem_req_*           - shared memory request port
//               mem_resp_rdata      - memory read data, LAT cycles later
//               perf_*_cnt          - saturating performance counters
// Parameters  : LAT   - memory read latency (1..4)
//               CNT_W - performance counter width
// Revision    : 1.0 - initial release
// ============================================================================
module proc_dmem_arb
    import proc_dmem_arb_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             p_req_val,
    output logic             p_req_rdy,
    input  logic             p_req_type,
    input  logic [31:0]      p_req_addr,
    input  logic [31:0]      p_req_wdata,
    output logic             p_resp_val,
    output logic [31:0]      p_resp_rdata,

    input  logic             x_req_val,
    output logic             x_req_rdy,
    input  logic             x_req_type,
    input  logic [31:0]      x_req_addr,
    input  logic [31:0]      x_req_wdata,
    output logic             x_resp_val,
    output logic [31:0]      x_resp_rdata,

    output logic             mem_req_val,
    output logic             mem_req_type,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_wdata,
    input  logic [31:0]      mem_resp_rdata,

    output logic [CNT_W-1:0] perf_conflict_cnt,
    output logic [CNT_W-1:0] perf_p_grant_cnt,
    output logic [CNT_W-1:0] perf_x_grant_cnt
);

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_p_fire;
    logic        w_x_fire;
    logic        w_fire;
    arb_tag_t    r_tag [LAT];
    arb_tag_t    w_last;
    logic [31:0] w_rdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req = {x_req_val, p_req_val};

    proc_dmem_arb_rr u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  (w_req),
        .fire (w_fire),
        .gnt  (w_gnt)
    );

    // Grant is already qualified by val, so rdy doubles as fire.
    assign p_req_rdy = w_gnt[0];
    assign x_req_rdy = w_gnt[1];
    assign w_p_fire  = p_req_val & w_gnt[0];
    assign w_x_fire  = x_req_val & w_gnt[1];
    assign w_fire    = w_p_fire | w_x_fire;

    // ------------------------------------------------------------------
    // Memory request mux; all-zero when nothing fires
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_val   = w_fire;
        mem_req_type  = MEM_READ;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (w_p_fire) begin
            mem_req_type  = p_req_type;
            mem_req_addr  = p_req_addr;
            mem_req_wdata = p_req_wdata;
        end else if (w_x_fire) begin
            mem_req_type  = x_req_type;
            mem_req_addr  = x_req_addr;
            mem_req_wdata = x_req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: LAT stages, shifted every cycle. The last stage lines
    // up with the cycle in which mem_resp_rdata is valid for that request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].val     <= w_fire;
            r_tag[0].owner   <= w_x_fire ? OWNER_X : OWNER_P;
            r_tag[0].is_read <= (mem_req_type == MEM_READ);
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_last = r_tag[LAT-1];

    // ------------------------------------------------------------------
    // Response demux; write acks carry zero data
    // ------------------------------------------------------------------
    assign w_rdata      = w_last.is_read ? mem_resp_rdata : '0;
    assign p_resp_val   = w_last.val & (w_last.owner == OWNER_P);
    assign x_resp_val   = w_last.val & (w_last.owner == OWNER_X);
    assign p_resp_rdata = p_resp_val ? w_rdata : '0;
    assign x_resp_rdata = x_resp_val ? w_rdata : '0;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef PROC_DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] r_conflict_cnt;
    logic [CNT_W-1:0] r_p_grant_cnt;
    logic [CNT_W-1:0] r_x_grant_cnt;

    // Each counter sticks at all-ones and clears only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_p_grant_cnt  <= '0;
            r_x_grant_cnt  <= '0;
        end else begin
            if (p_req_val && x_req_val && !(&r_conflict_cnt)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
            if (w_p_fire && !(&r_p_grant_cnt)) begin
                r_p_grant_cnt <= r_p_grant_cnt + CNT_W'(1);
            end
            if (w_x_fire && !(&r_x_grant_cnt)) begin
                r_x_grant_cnt <= r_x_grant_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_conflict_cnt = r_conflict_cnt;
    assign perf_p_grant_cnt  = r_p_grant_cnt;
    assign perf_x_grant_cnt  = r_x_grant_cnt;
`else
    assign perf_conflict_cnt = '0;
    assign perf_p_grant_cnt  = '0;
    assign perf_x_grant_cnt  = '0;
`endif

endmodule
`default_nettype wire
